dram_sequencer: RTL

- Clocked DRAM timing sequencer for the VG8020 slot-3 RAM bank. Replaces the combinational nRAS/MUX gating with explicit state-machine timing.
- Samples Z80 bus strobes on an oversampled system clock. Drives nRAS, row/column MUX, nCAS and nWE for 4164/41256-class parts.
- Arbitrates between CPU memory cycles and Z80 refresh cycles.
- Sits between the Z80 bus decode (nmreq, nrd, nwr, nrfsh, nsltsl3) and the DRAM array and address multiplexer.

---
 rtl/dram_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_sequencer.sv
// ---------------------------------------------------------------------------
// dram_sequencer
//
// Clocked DRAM timing sequencer for the VG8020 slot-3 RAM bank. It samples
// the Z80 bus strobes on an oversampled system clock and generates nRAS, the
// row/column address mux select, nCAS and nWE for 4164/41256-class DRAMs.
// It arbitrates between CPU memory cycles and Z80 RAS-only refresh cycles.
//
// Ports:
//   clk      in   system clock, all inputs sampled on its rising edge
//   reset    in   synchronous active-high reset
//   nmreq    in   Z80 memory request (active low)
//   nrd      in   Z80 read strobe (active low)
//   nwr      in   Z80 write strobe (active low)
//   nrfsh    in   Z80 refresh (active low)
//   nsltsl3  in   slot 3 RAM select (active low)
//   nras     out  DRAM row strobe (active low, registered)
//   mux      out  address mux select, 0 = row, 1 = column (registered)
//   ncas     out  DRAM column strobe (active low, registered)
//   nwe      out  DRAM write enable (active low, registered)
//   busy     out  high whenever the sequencer is not idle (registered)
//
// Optional build macro: DRAM_SEQUENCER_WATCHDOG_REFRESH_EN
//   When defined, a 10-bit watchdog counts cycles since the last refresh and
//   runs a CAS-before-RAS refresh on its own once REFRESH_TIMEOUT is reached
//   while the bus is idle. When undefined, refresh comes only from Z80 RFSH.
// ---------------------------------------------------------------------------
module dram_sequencer #(
    parameter int RAS_TO_MUX      = 1,
    parameter int MUX_TO_CAS      = 1,
    parameter int PRECHARGE       = 2,
    parameter int REFRESH_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic nmreq,
    input  logic nrd,
    input  logic nwr,
    input  logic nrfsh,
    input  logic nsltsl3,
    output logic nras,
    output logic mux,
    output logic ncas,
    output logic nwe,
    output logic busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROW     = 3'd1,
        ST_COL     = 3'd2,
        ST_CAS     = 3'd3,
        ST_RFSH    = 3'd4,
`ifdef DRAM_SEQUENCER_WATCHDOG_REFRESH_EN
        ST_PRE     = 3'd5,
        ST_CBR_CAS = 3'd6,
        ST_CBR_RAS = 3'd7
`else
        ST_PRE     = 3'd5
`endif
    } state_t;

    // Limits are held one bit wider than the counter so cnt+1 never wraps
    // in the comparison and the CBR RAS phase can reach 16.
    localparam logic [4:0] ROW_LIM_C = 5'(RAS_TO_MUX);
    localparam logic [4:0] MUX_LIM_C = 5'(MUX_TO_CAS);
    localparam logic [4:0] PRE_LIM_C = 5'(PRECHARGE);
`ifdef DRAM_SEQUENCER_WATCHDOG_REFRESH_EN
    localparam logic [4:0] CBR_LIM_C = 5'(RAS_TO_MUX + 1);
    localparam logic [9:0] WD_LIM_C  = 10'(REFRESH_TIMEOUT);
`endif

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        nwe_nxt_s;
    logic        strobe_s;
`ifdef DRAM_SEQUENCER_WATCHDOG_REFRESH_EN
    logic [9:0]  wd_cnt_r;
`endif

    // True once the current state has lasted 'lim' cycles, counting this edge.
    function automatic logic cnt_done(input logic [3:0] cnt, input logic [4:0] lim);
        cnt_done = (({1'b0, cnt} + 5'd1) >= lim);
    endfunction

    // Saturating increment: the phase counter holds at 15 instead of wrapping.
    function automatic logic [3:0] cnt_inc(input logic [3:0] cnt);
        if (cnt == 4'hF) begin
            cnt_inc = cnt;
        end else begin
            cnt_inc = cnt + 4'd1;
        end
    endfunction

    // Strobe levels {nras, mux, ncas, busy} presented while in a given state.
    // Unused encodings map to the all-inactive precharge pattern.
    function automatic logic [3:0] state_outs(input state_t st);
        case (st)
            ST_IDLE:    state_outs = 4'b1010;
            ST_ROW:     state_outs = 4'b0011;
            ST_COL:     state_outs = 4'b0111;
            ST_CAS:     state_outs = 4'b0101;
            ST_RFSH:    state_outs = 4'b0011;
            ST_PRE:     state_outs = 4'b1011;
`ifdef DRAM_SEQUENCER_WATCHDOG_REFRESH_EN
            ST_CBR_CAS: state_outs = 4'b1001;
            ST_CBR_RAS: state_outs = 4'b0001;
`endif
            default:    state_outs = 4'b1011;
        endcase
    endfunction

    assign strobe_s = (~nrd) | (~nwr);

    // Next-state, phase counter and write-enable decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        nwe_nxt_s   = 1'b1;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 4'd0;
                // Refresh wins over a slot-3 select presented at the same time.
                if (!nmreq && !nrfsh) begin
                    state_nxt_s = ST_RFSH;
                end else if (!nmreq && !nsltsl3) begin
                    state_nxt_s = ST_ROW;
`ifdef DRAM_SEQUENCER_WATCHDOG_REFRESH_EN
                end else if (nmreq && (wd_cnt_r == WD_LIM_C)) begin
                    state_nxt_s = ST_CBR_CAS;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROW: begin
                if (nmreq) begin
                    state_nxt_s = ST_PRE;
                    cnt_nxt_s   = 4'd0;
                end else if (cnt_done(cnt_r, ROW_LIM_C)) begin
                    state_nxt_s = ST_COL;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s   = cnt_inc(cnt_r);
                end
            end
            ST_COL: begin
                // Waiting here without a strobe covers the Z80 late write.
                if (nmreq) begin
                    state_nxt_s = ST_PRE;
                    cnt_nxt_s   = 4'd0;
                end else if (cnt_done(cnt_r, MUX_LIM_C) && strobe_s) begin
                    state_nxt_s = ST_CAS;
                    cnt_nxt_s   = 4'd0;
                    nwe_nxt_s   = nwr;
                end else begin
                    cnt_nxt_s   = cnt_inc(cnt_r);
                end
            end
            ST_CAS: begin
                if (nmreq) begin
                    state_nxt_s = ST_PRE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    // Once a write is seen, nwe stays low until the cycle ends.
                    nwe_nxt_s   = nwe & nwr;
                end
            end
            ST_RFSH: begin
                if (nmreq) begin
                    state_nxt_s = ST_PRE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_RFSH;
                end
            end
            ST_PRE: begin
                if (cnt_done(cnt_r, PRE_LIM_C)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s   = cnt_inc(cnt_r);
                end
            end
`ifdef DRAM_SEQUENCER_WATCHDOG_REFRESH_EN
            ST_CBR_CAS: begin
                state_nxt_s = ST_CBR_RAS;
                cnt_nxt_s   = 4'd0;
            end
            ST_CBR_RAS: begin
                if (cnt_done(cnt_r, CBR_LIM_C)) begin
                    state_nxt_s = ST_PRE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s   = cnt_inc(cnt_r);
                end
            end
`endif
            default: begin
                state_nxt_s = ST_PRE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            nras    <= 1'b1;
            mux     <= 1'b0;
            ncas    <= 1'b1;
            nwe     <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            {nras, mux, ncas, busy} <= state_outs(state_nxt_s);
            nwe     <= nwe_nxt_s;
        end
    end

`ifdef DRAM_SEQUENCER_WATCHDOG_REFRESH_EN
    // Refresh watchdog: cleared on any refresh start, saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= 10'd0;
        end else if ((state_r == ST_IDLE) &&
                     ((state_nxt_s == ST_RFSH) || (state_nxt_s == ST_CBR_CAS))) begin
            wd_cnt_r <= 10'd0;
        end else if (wd_cnt_r != WD_LIM_C) begin
            wd_cnt_r <= wd_cnt_r + 10'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`endif

endmodule
